exec_alu: RTL

//  Parametrised, registered execute-stage ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/muldiv_iter.sv | 148 ++++++++++++++
 rtl/exec_alu.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the execute-stage ALU: operation encoding,
//            control FSM states and the multiply/divide classifier.
// Contents : alu_op_e  - 5-bit operation code (RV32I ALU ops + RV32M ops)
//            state_e   - exec_alu control FSM states
//            is_muldiv - true for any RV32M operation code
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // RV32M codes occupy 16..23 so they can be recognised from op[4:3] alone.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative RV32M unit. Shift-add multiplier and restoring divider
//            working on operand magnitudes, with sign fix-up on the output.
//            One iteration is done on the start edge and XLEN-1 more while
//            busy, so done rises XLEN-1 cycles after start.
// Ports    : clk     in   core clock
//            rst_n   in   asynchronous active-low reset
//            start   in   latch operands and begin (restarts any op in flight)
//            op      in   alu_op_e code (RV32M codes only are meaningful)
//            a, b    in   XLEN operands (dividend/divisor for divides)
//            busy    out  iterations still in progress
//            done    out  result valid; held until the next start
//            result  out  XLEN result
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  logic            r_busy, r_done, r_div, r_sel_hi, r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_m;

  logic            w_div, w_a_signed, w_b_signed, w_sel_hi;
  logic            w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_init_m, w_init_lo;
  logic [XLEN-1:0] w_hi, w_lo, w_m, w_nxt_hi, w_nxt_lo, w_diff;
  logic            w_is_div, w_ge;
  logic [XLEN:0]   w_shift, w_sum;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_word, w_word_fix;

  always_comb begin
    w_div      = 1'b0;
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    w_sel_hi   = 1'b0;
    case (op)
      ALU_MULH:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; w_sel_hi = 1'b1; end
      ALU_MULHSU: begin w_a_signed = 1'b1; w_sel_hi = 1'b1; end
      ALU_MULHU:  w_sel_hi = 1'b1;
      ALU_DIV:    begin w_div = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; end
      ALU_DIVU:   w_div = 1'b1;
      ALU_REM:    begin w_div = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_sel_hi = 1'b1; end
      ALU_REMU:   begin w_div = 1'b1; w_sel_hi = 1'b1; end
      default:    w_div = 1'b0;
    endcase
  end

  assign w_sa    = w_a_signed & a[XLEN-1];
  assign w_sb    = w_b_signed & b[XLEN-1];
  assign w_abs_a = w_sa ? (~a + 1'b1) : a;
  assign w_abs_b = w_sb ? (~b + 1'b1) : b;

  // Quotient keeps the all-ones magnitude on divide-by-zero (no negation);
  // the remainder always takes the dividend's sign.
  always_comb begin
    if (w_div && w_sel_hi) w_neg = w_sa;
    else if (w_div)        w_neg = (w_sa ^ w_sb) && (b != '0);
    else                   w_neg = w_sa ^ w_sb;
  end

  // Multiply: r_m = multiplicand, r_lo = multiplier shifting out.
  // Divide:   r_m = divisor,      r_lo = dividend shifting into quotient.
  assign w_init_m  = w_div ? w_abs_b : w_abs_a;
  assign w_init_lo = w_div ? w_abs_a : w_abs_b;

  assign w_hi     = start ? '0        : r_hi;
  assign w_lo     = start ? w_init_lo : r_lo;
  assign w_m      = start ? w_init_m  : r_m;
  assign w_is_div = start ? w_div     : r_div;

  assign w_shift = {w_hi, w_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, w_m});
  // Only used when w_ge, where the true difference is below the divisor.
  assign w_diff  = w_shift[XLEN-1:0] - w_m;
  assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_m} : '0);

  always_comb begin
    if (w_is_div) begin
      w_nxt_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
      w_nxt_lo = {w_lo[XLEN-2:0], w_ge};
    end else begin
      w_nxt_hi = w_sum[XLEN:1];
      w_nxt_lo = {w_sum[0], w_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div    <= 1'b0;
      r_sel_hi <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_div    <= w_div;
      r_sel_hi <= w_sel_hi;
      r_neg    <= w_neg;
      r_cnt    <= CNT_W'(XLEN - 1);
      r_hi     <= w_nxt_hi;
      r_lo     <= w_nxt_lo;
      r_m      <= w_init_m;
    end else if (r_busy) begin
      r_hi  <= w_nxt_hi;
      r_lo  <= w_nxt_lo;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_word     = r_sel_hi ? r_hi : r_lo;
  assign w_word_fix = r_neg ? (~w_word + 1'b1) : w_word;

  assign result = r_div    ? w_word_fix :
                  r_sel_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu
// Purpose  : Registered execute-stage ALU with valid/ready on both sides.
//            RV32I ops complete in one cycle; RV32M ops run through
//            muldiv_iter and stall the input for XLEN+1 cycles.
// Config   : ALU_MULDIV_EN - when defined, RV32M ops execute; otherwise they
//            are reported as illegal with a one-cycle latency.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            flush               kills in-flight op and output register
//            in_valid/in_ready   input handshake
//            in_op               alu_op_e code
//            in_use_imm          select in_imm (1) or in_rs2 (0) as operand B
//            in_rs1/in_rs2/in_imm XLEN operands
//            out_valid/out_ready output handshake
//            out_result          XLEN result
//            out_illegal         op unsupported in this build, result is 0
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_e          r_state, w_state_nxt;
  logic            r_out_valid, r_out_illegal;
  logic [XLEN-1:0] r_out_result;

  logic            w_accept, w_md_start, w_md_done, w_done_load;
  logic [XLEN-1:0] w_md_result;
  logic [XLEN-1:0] w_b, w_base_result;
  logic            w_base_illegal;
  logic [SHAMT_W-1:0] w_shamt;

  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  // flush blocks acceptance even when in_ready is high.
  assign w_accept = in_valid && in_ready && !flush;
  assign w_b      = in_use_imm ? in_imm : in_rs2;
  assign w_shamt  = w_b[SHAMT_W-1:0];

  always_comb begin
    w_base_result  = '0;
    w_base_illegal = 1'b0;
    case (in_op)
      ALU_ADD:  w_base_result = in_rs1 + w_b;
      ALU_SUB:  w_base_result = in_rs1 - w_b;
      ALU_AND:  w_base_result = in_rs1 & w_b;
      ALU_OR:   w_base_result = in_rs1 | w_b;
      ALU_XOR:  w_base_result = in_rs1 ^ w_b;
      ALU_SLL:  w_base_result = in_rs1 << w_shamt;
      ALU_SRL:  w_base_result = in_rs1 >> w_shamt;
      ALU_SRA:  w_base_result = $signed(in_rs1) >>> w_shamt;
      ALU_SLT:  w_base_result = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(w_b))};
      ALU_SLTU: w_base_result = {{(XLEN-1){1'b0}}, (in_rs1 < w_b)};
      default:  w_base_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic w_md_busy;

  assign w_md_start = w_accept && is_muldiv(in_op);

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_md_start),
    .op     (in_op),
    .a      (in_rs1),
    .b      (w_b),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .result (w_md_result)
  );
`else
  logic w_md_busy;

  assign w_md_start  = 1'b0;
  assign w_md_busy   = 1'b0;
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_md_start) w_state_nxt = RUN;
        RUN:     if (w_md_done && !w_md_busy) w_state_nxt = DONE;
        DONE:    if (!r_out_valid || out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_done_load = (r_state == DONE) && (!r_out_valid || out_ready) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_md_start) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= w_base_result;
      r_out_illegal <= w_base_illegal;
    end else if (w_done_load) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= w_md_result;
      r_out_illegal <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_illegal = r_out_illegal;

endmodule
`default_nettype wire
